ambtc_hidden_decode: RTL and testbench

- Recovers the 512-character string hidden by the encode stage in an AMBTC-compressed 64x64 image.
- Walks the image block by block (4x4 blocks, raster order) over the same row/col/in_pix image-read interface the processing FSM uses.
- Extracts one 16-bit word (two characters) per block from the ±1 perturbations of the green channel.
- Assembles the words into an 8*512-bit string register for the testbench or host.

---
 rtl/ambtc_hidden_decode.sv | 180 ++++++++++++++++++
 tb/tb_ambtc_hidden_decode.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ambtc_hidden_decode.sv
// AMBTC hidden-string decoder: walks the 64x64 image in 4x4 blocks, recovers one
// 16-bit word per block from +/-1 perturbations of the green channel and packs
// the words into a flat string register (char 0 in the top byte).
module ambtc_hidden_decode #(
    parameter int unsigned IMG_SIZE = 64,
    parameter int unsigned BLK      = 4,
    parameter int unsigned TRITS    = 11,
    parameter int unsigned NCHARS   = 512
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [23:0]         in_pix,
    output logic [5:0]          row,
    output logic [5:0]          col,
    output logic                busy,
    output logic                decode_done,
    output logic                err,
    output logic [8*NCHARS-1:0] decoded_string
);

    localparam int unsigned BPS      = IMG_SIZE / BLK;
    localparam logic [3:0]  LAST_BLK = 4'(BPS - 1);
    localparam logic [3:0]  N_TRITS  = 4'(TRITS);
    localparam logic [11:0] TOP_LSB  = 12'(8 * NCHARS - 16);

    typedef enum logic [2:0] {StIdle, StScan, StDecode, StStore, StDone} state_t;

    state_t      r_state;
    logic [3:0]  r_blkr;
    logic [3:0]  r_blkc;
    logic [3:0]  r_pix;
    logic [7:0]  r_a;
    logic [7:0]  r_b;
    logic [3:0]  r_pb;
    logic        r_hasb;
    logic [17:0] r_acc;
    logic [17:0] r_w;
    logic [3:0]  r_k;

    logic [7:0]        w_g;
    logic signed [8:0] w_da;
    logic signed [8:0] w_db;
    logic signed [8:0] w_d;
    logic              w_near_a;
    logic              w_far_a;
    logic              w_bad;
    logic [1:0]        w_trit;
    logic              w_carrier;
    logic              w_use;
    logic [17:0]       w_addend;
    logic [3:0]        w_pix_nxt;
    logic [11:0]       w_lsb;
    logic              w_unused;

    // Only the green channel carries payload.
    assign w_unused = ^{in_pix[23:16], in_pix[7:0]};

    // Pixel classification and trit extraction for the current pixel.
    always_comb begin
        w_g      = in_pix[15:8];
        w_da     = $signed({1'b0, w_g}) - $signed({1'b0, r_a});
        w_db     = $signed({1'b0, w_g}) - $signed({1'b0, r_b});
        w_near_a = (w_da >= -9'sd1) && (w_da <= 9'sd1);
        w_far_a  = (w_da >= 9'sd3) || (w_da <= -9'sd3);
        w_d      = w_near_a ? w_da : w_db;
        w_trit   = 2'd0;
        w_bad    = 1'b0;
        if (!w_near_a && !r_hasb) begin
            w_bad = 1'b1;
        end else if (w_d == 9'sd1) begin
            w_trit = 2'd1;
        end else if (w_d == -9'sd1) begin
            w_trit = 2'd2;
        end else if (w_d != 9'sd0) begin
            w_bad = 1'b1;
        end
        w_carrier = (r_pix != 4'd0) && !(r_hasb && (r_pix == r_pb));
        w_use     = w_carrier && (r_k < N_TRITS);
        case (w_trit)
            2'd1:    w_addend = r_w;
            2'd2:    w_addend = r_w << 1;
            default: w_addend = '0;
        endcase
        w_pix_nxt = r_pix + 4'd1;
        // Block n lands at the 16-bit slot counted down from the top of the string.
        w_lsb     = TOP_LSB - {r_blkr, r_blkc, 4'b0000};
    end

    // Control FSM, address generation, accumulation and string assembly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= StIdle;
            r_blkr         <= '0;
            r_blkc         <= '0;
            r_pix          <= '0;
            r_a            <= '0;
            r_b            <= '0;
            r_pb           <= '0;
            r_hasb         <= 1'b0;
            r_acc          <= '0;
            r_w            <= '0;
            r_k            <= '0;
            row            <= '0;
            col            <= '0;
            busy           <= 1'b0;
            decode_done    <= 1'b0;
            err            <= 1'b0;
            decoded_string <= '0;
        end else begin
            case (r_state)
                StIdle, StDone: begin
                    if (start) begin
                        r_state     <= StScan;
                        r_blkr      <= '0;
                        r_blkc      <= '0;
                        r_pix       <= '0;
                        row         <= '0;
                        col         <= '0;
                        busy        <= 1'b1;
                        decode_done <= 1'b0;
                        // err is sticky across runs; only the string is cleared.
                        decoded_string <= '0;
                    end
                end
                StScan: begin
                    if (r_pix == 4'd0) begin
                        r_a    <= w_g;
                        r_hasb <= 1'b0;
                        r_acc  <= '0;
                        r_w    <= 18'd1;
                        r_k    <= '0;
                    end else if (!r_hasb && w_far_a) begin
                        r_b    <= w_g;
                        r_pb   <= r_pix;
                        r_hasb <= 1'b1;
                    end
                    r_pix <= w_pix_nxt;
                    row   <= {r_blkr, w_pix_nxt[3:2]};
                    col   <= {r_blkc, w_pix_nxt[1:0]};
                    if (r_pix == 4'd15) r_state <= StDecode;
                end
                StDecode: begin
                    if (w_use) begin
                        if (w_bad) err <= 1'b1;
                        r_acc <= r_acc + w_addend;
                        r_w   <= r_w + (r_w << 1);
                        r_k   <= r_k + 4'd1;
                    end
                    r_pix <= w_pix_nxt;
                    row   <= {r_blkr, w_pix_nxt[3:2]};
                    col   <= {r_blkc, w_pix_nxt[1:0]};
                    if (r_pix == 4'd15) r_state <= StStore;
                end
                StStore: begin
                    if ((r_k < N_TRITS) || (r_acc[17:16] != 2'b00)) err <= 1'b1;
                    decoded_string[w_lsb +: 16] <= r_acc[15:0];
                    if ((r_blkr == LAST_BLK) && (r_blkc == LAST_BLK)) begin
                        r_state     <= StDone;
                        busy        <= 1'b0;
                        decode_done <= 1'b1;
                    end else begin
                        r_state <= StScan;
                        r_pix   <= '0;
                        r_blkc  <= r_blkc + 4'd1;
                        col     <= {r_blkc + 4'd1, 2'b00};
                        if (r_blkc == LAST_BLK) begin
                            r_blkr <= r_blkr + 4'd1;
                            row    <= {r_blkr + 4'd1, 2'b00};
                        end else begin
                            row    <= {r_blkr, 2'b00};
                        end
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_ambtc_hidden_decode.sv
// Bench for ambtc_hidden_decode: image memory, a block-level reference decoder,
// a per-cycle timeline checker, and directed images with literal expectations.
module tb_ambtc_hidden_decode;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [23:0]   in_pix;
    logic [5:0]    row;
    logic [5:0]    col;
    logic          busy;
    logic          decode_done;
    logic          err;
    logic [4095:0] decoded_string;

    logic [7:0]    img [0:63][0:63];
    logic [4095:0] exp_str;
    logic          exp_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_cyc = 0;
    bit run_active = 1'b0;

    ambtc_hidden_decode dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .in_pix         (in_pix),
        .row            (row),
        .col            (col),
        .busy           (busy),
        .decode_done    (decode_done),
        .err            (err),
        .decoded_string (decoded_string)
    );

    // Asynchronous image read; R and B are scrambled so only G may matter.
    assign in_pix = {~img[row][col], img[row][col], img[row][col] ^ 8'h5a};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_str(input string name, input logic [4095:0] act, input logic [4095:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            for (int n = 0; n < 256; n++) begin
                if (act[4095-16*n -: 16] !== exp[4095-16*n -: 16]) begin
                    $display("FAIL %s: block %0d word got 0x%04h expected 0x%04h", name, n,
                             act[4095-16*n -: 16], exp[4095-16*n -: 16]);
                    break;
                end
            end
        end
    endtask

    function automatic int iabs(input int x);
        return (x < 0) ? -x : x;
    endfunction

    // Reference decoder: per block, pick A/B, list carriers, sum trits in base 3.
    task automatic compute_model();
        exp_str = '0;
        exp_err = 1'b0;
        for (int br = 0; br < 16; br++) begin
            for (int bc = 0; bc < 16; bc++) begin
                int g[16];
                int a, pb, k, word, pw, d, t;
                for (int p = 0; p < 16; p++) g[p] = int'(img[br*4 + p/4][bc*4 + p%4]);
                a  = g[0];
                pb = -1;
                for (int p = 1; p < 16; p++) if (pb < 0 && iabs(g[p] - a) >= 3) pb = p;
                k = 0; word = 0; pw = 1;
                for (int p = 1; p < 16; p++) begin
                    if (p != pb && k < 11) begin
                        t = 0;
                        if (iabs(g[p] - a) <= 1) d = g[p] - a;
                        else if (pb < 0) d = 1000;
                        else d = g[p] - g[pb];
                        if (d == 1) t = 1;
                        else if (d == -1) t = 2;
                        else if (d != 0) exp_err = 1'b1;
                        word += t * pw;
                        pw *= 3;
                        k++;
                    end
                end
                if (k < 11 || word > 65535) exp_err = 1'b1;
                exp_str[4095 - 16*(br*16 + bc) -: 16] = 16'(word);
            end
        end
    endtask

    task automatic put(input int br, input int bc, input int p, input int v);
        img[br*4 + p/4][bc*4 + p%4] = 8'(v);
    endtask

    // Hand vector; pixel 0 in the top byte.
    task automatic set_block(input int br, input int bc, input logic [127:0] v);
        for (int p = 0; p < 16; p++) put(br, bc, p, int'(v[127-8*p -: 8]));
    endtask

    // Encoder with B at p=1; each trit randomly rides on A or on B.
    task automatic enc_block(input int br, input int bc, input int word, input int a);
        int w, b, t, base;
        w = word;
        b = a + 10;
        put(br, bc, 0, a);
        put(br, bc, 1, b);
        for (int k = 0; k < 11; k++) begin
            t = w % 3;
            w = w / 3;
            base = ($urandom_range(0, 1) == 1) ? a : b;
            put(br, bc, k + 2, base + ((t == 1) ? 1 : (t == 2) ? -1 : 0));
        end
        for (int p = 13; p < 16; p++) put(br, bc, p, b);
    endtask

    task automatic fill_uniform(input int v);
        for (int r = 0; r < 64; r++) for (int c = 0; c < 64; c++) img[r][c] = 8'(v);
    endtask

    task automatic fill_encoded();
        for (int br = 0; br < 16; br++)
            for (int bc = 0; bc < 16; bc++)
                enc_block(br, bc, int'($urandom_range(0, 65535)), int'($urandom_range(20, 200)));
        set_block(0, 0, {8'd50, 8'd60, 8'd49, 8'd50, 8'd49, 8'd50, 8'd49, 8'd49,
                         8'd51, 8'd51, 8'd49, 8'd50, 8'd50, 8'd60, 8'd60, 8'd60});
    endtask

    // Timeline checker: busy/done and the block/pixel address each cycle of a run.
    always @(negedge clk) begin
        int t, w, p, b;
        if (run_active) begin
            t = cyc - start_cyc;
            if (t >= 1) begin
                chk("busy", 32'(busy), 32'(t <= 8448));
                chk("decode_done", 32'(decode_done), 32'(t >= 8449));
                if (t <= 8448) begin
                    w = (t - 1) % 33;
                    b = (t - 1) / 33;
                    if (w < 32) begin
                        p = w % 16;
                        chk("row", 32'(row), 32'((b / 16) * 4 + p / 4));
                        chk("col", 32'(col), 32'((b % 16) * 4 + p % 4));
                    end
                end
            end
        end
    end

    task automatic run_start();
        @(negedge clk);
        start      = 1'b1;
        start_cyc  = cyc;
        run_active = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!decode_done && n < 9000) begin
            @(negedge clk);
            n++;
        end
        chk("done_cycle", 32'(cyc - start_cyc), 32'd8449);
    endtask

    initial begin
        rst   = 1'b0;
        start = 1'b0;
        fill_uniform(100);
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(decode_done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_rowcol", 32'({row, col}), 32'd0);
        chk_str("rst_string", decoded_string, '0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Uniform image, plus a start pulse mid-run that must be ignored.
        compute_model();
        chk("model_uniform_err", 32'(exp_err), 32'd0);
        run_start();
        repeat (99) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        chk_str("uniform_string", decoded_string, exp_str);
        chk("uniform_err", 32'(err), 32'd0);

        // Encoded image with the "AB" block first.
        fill_encoded();
        compute_model();
        chk("model_ab_word", 32'(exp_str[4095 -: 16]), 32'h4142);
        chk("model_ab_err", 32'(exp_err), 32'd0);
        run_start();
        wait_done();
        chk_str("encoded_string", decoded_string, exp_str);
        chk("char0_A", 32'(decoded_string[4095 -: 8]), 32'h41);
        chk("char1_B", 32'(decoded_string[4087 -: 8]), 32'h42);
        chk("encoded_err", 32'(err), 32'd0);

        // Malformed blocks: overflow, carrier needing absent B, |d|>1 against B.
        set_block(0, 0, {8'd50, 8'd60, {11{8'd49}}, 8'd60, 8'd60, 8'd60});
        set_block(0, 1, {8'd50, 8'd51, 8'd49, 8'd52, 8'd51, {11{8'd50}}});
        set_block(0, 2, {8'd50, 8'd60, 8'd53, 8'd61, 8'd49, {11{8'd50}}});
        compute_model();
        chk("model_ovf_word", 32'(exp_str[4095 -: 16]), 32'hB3FA);
        chk("model_nob_word", 32'(exp_str[4079 -: 16]), 32'h0022);
        chk("model_bigd_word", 32'(exp_str[4063 -: 16]), 32'h0015);
        chk("model_bad_err", 32'(exp_err), 32'd1);
        run_start();
        wait_done();
        chk_str("bad_string", decoded_string, exp_str);
        chk("ovf_chars", 32'(decoded_string[4095 -: 16]), 32'hB3FA);
        chk("nob_word", 32'(decoded_string[4079 -: 16]), 32'h0022);
        chk("bad_err", 32'(err), 32'd1);

        // Restart from DONE: string cleared, err sticky; then async reset mid-run.
        run_start();
        chk_str("restart_cleared", decoded_string, '0);
        chk("restart_err_sticky", 32'(err), 32'd1);
        while (cyc - start_cyc < 2999) @(negedge clk);
        run_active = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(decode_done), 32'd0);
        chk("abort_err", 32'(err), 32'd0);
        chk("abort_rowcol", 32'({row, col}), 32'd0);
        chk_str("abort_string", decoded_string, '0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Full decode after the abort.
        fill_encoded();
        compute_model();
        run_start();
        wait_done();
        chk_str("post_reset_string", decoded_string, exp_str);
        chk("post_reset_err", 32'(err), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
